// File: rtl/expansion_irq_ctrl_if.sv
// CPU bus snoop bundle for the expansion interrupt injector.
// Handshake: a bus cycle is live while AS_n is low; a write is qualified by RW=0 with
// UDS_n or LDS_n low, a read by RW=1. The slave acts once per AS_n-low period.
interface expansion_irq_ctrl_if;
  logic [23:1] ADDR;
  logic [15:0] DATA_IN;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;

  modport master (output ADDR, DATA_IN, AS_n, UDS_n, LDS_n, RW);
  modport slave  (input  ADDR, DATA_IN, AS_n, UDS_n, LDS_n, RW);
endinterface

// File: rtl/expansion_irq_ctrl.sv
// Expansion interrupt injector: merges on-board sources into the CPU IPL at level 2/6.
// Optional macro IRQ_SYNC_EN selects a 2-flop input synchroniser (default: 1 capture flop).
module expansion_irq_ctrl #(
  parameter int         NUM_SRC     = 2,
  parameter logic [7:0] LEVEL6_MASK = 8'h00,
  parameter logic [7:0] EDGE_MASK   = 8'h00
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  expansion_irq_ctrl_if.slave  bus,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [2:0]           ipl_in,
  output logic [2:0]           ipl_out,
  output logic                 ovr_ports,
  output logic                 ovr_exter,
  output logic [NUM_SRC-1:0]   pending
);

  localparam logic [NUM_SRC-1:0] L6_MASK = LEVEL6_MASK[NUM_SRC-1:0];
  localparam logic [NUM_SRC-1:0] ED_MASK = EDGE_MASK[NUM_SRC-1:0];

  logic               r_ports_en, r_exter_en, r_master_en;
  logic               r_ack;
  logic               r_int2, r_int6;
  logic               r_ovr_ports, r_ovr_exter;
  logic [NUM_SRC-1:0] r_sync, r_prev, r_edge;

  logic               w_custom, w_wr, w_rd_intreqr;
  logic               w_wr_intena, w_wr_intreq;
  logic [NUM_SRC-1:0] w_clr, w_rise, w_pending;
  logic               w_unused;

  assign w_custom     = (bus.ADDR[23:16] == 8'hDF);
  assign w_wr         = w_custom & ~bus.AS_n & ~bus.RW & (~bus.UDS_n | ~bus.LDS_n) & ~r_ack;
  assign w_wr_intena  = w_wr & (bus.ADDR[11:1] == 11'h04D);
  assign w_wr_intreq  = w_wr & (bus.ADDR[11:1] == 11'h04E);
  assign w_rd_intreqr = w_custom & ~bus.AS_n & bus.RW & (bus.ADDR[11:1] == 11'h00F);
  assign w_unused     = ^{bus.ADDR[15:12], bus.DATA_IN[12:4], bus.DATA_IN[2:0]};

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_meta;
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= irq_src;
      r_sync <= r_meta;
    end
  end
`else
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) r_sync <= '0;
    else          r_sync <= irq_src;
  end
`endif

  // INTREQ clears apply only when the SET bit (15) is zero.
  assign w_clr = (w_wr_intreq && !bus.DATA_IN[15]) ?
                 (({NUM_SRC{bus.DATA_IN[3]}}  & ~L6_MASK) |
                  ({NUM_SRC{bus.DATA_IN[13]}} &  L6_MASK)) : '0;
  assign w_rise    = r_sync & ~r_prev;
  assign w_pending = (ED_MASK & r_edge) | (~ED_MASK & r_sync);
  assign pending   = w_pending;

  // Set is ORed in after the clear so a coincident new edge is never lost.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_prev <= r_sync;
      r_edge <= ((r_edge & ~w_clr) | w_rise) & ED_MASK;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_ack       <= 1'b0;
      r_ports_en  <= 1'b0;
      r_exter_en  <= 1'b0;
      r_master_en <= 1'b0;
    end else begin
      if (bus.AS_n)  r_ack <= 1'b0;
      else if (w_wr) r_ack <= 1'b1;
      if (w_wr_intena) begin
        if (bus.DATA_IN[3])  r_ports_en  <= bus.DATA_IN[15];
        if (bus.DATA_IN[13]) r_exter_en  <= bus.DATA_IN[15];
        if (bus.DATA_IN[14]) r_master_en <= bus.DATA_IN[15];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_int2      <= 1'b0;
      r_int6      <= 1'b0;
      r_ovr_ports <= 1'b0;
      r_ovr_exter <= 1'b0;
    end else begin
      r_int2      <= r_master_en & r_ports_en & (|(w_pending & ~L6_MASK));
      r_int6      <= r_master_en & r_exter_en & (|(w_pending &  L6_MASK));
      r_ovr_ports <= w_rd_intreqr & r_int2;
      r_ovr_exter <= w_rd_intreqr & r_int6;
    end
  end

  assign ovr_ports = r_ovr_ports;
  assign ovr_exter = r_ovr_exter;

  // IPL is active-low: a numerically larger code is a lower CPU level.
  always_comb begin
    ipl_out = ipl_in;
    if (r_int6 && (ipl_in > 3'b001))      ipl_out = 3'b001;
    else if (r_int2 && (ipl_in > 3'b101)) ipl_out = 3'b101;
  end

endmodule
